mem_port_arb: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_port_arb.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arb.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-to-one memory port arbiter: FSM states, owner
// encoding, tag/counter widths and the conflict-resolution helper.
package mem_arb_pkg;

   localparam int TAG_W = 11;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_RESP  = 2'd2,
      ST_LOCAL = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_e;

   // On a conflict with round-robin enabled, the side not granted last wins.
   function automatic owner_e pick_owner(input logic   i_d_req,
                                         input logic   i_i_req,
                                         input logic   i_rr,
                                         input owner_e i_last);
      if (!i_d_req) return OWNER_I;
      if (!i_i_req || !i_rr) return OWNER_D;
      return (i_last == OWNER_I) ? OWNER_D : OWNER_I;
   endfunction

endpackage

// File: rtl/mem_port_arb.sv
// Arbitrates the instruction-fetch and data ports onto one memory port,
// one transaction at a time, with local maintenance acks and a response watchdog.
module mem_port_arb
   import mem_arb_pkg::*;
#(
   parameter int ROUND_ROBIN    = 1,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             mem_i_rd_i,
   input  logic [31:0]      mem_i_pc_i,
   input  logic             mem_i_flush_i,
   input  logic             mem_i_invalidate_i,
   output logic             mem_i_accept_o,
   output logic             mem_i_valid_o,
   output logic             mem_i_error_o,
   output logic [31:0]      mem_i_inst_o,
   input  logic [31:0]      mem_d_addr_i,
   input  logic [31:0]      mem_d_data_wr_i,
   input  logic             mem_d_rd_i,
   input  logic [3:0]       mem_d_wr_i,
   input  logic             mem_d_cacheable_i,
   input  logic [TAG_W-1:0] mem_d_req_tag_i,
   input  logic             mem_d_invalidate_i,
   input  logic             mem_d_writeback_i,
   input  logic             mem_d_flush_i,
   output logic             mem_d_accept_o,
   output logic             mem_d_ack_o,
   output logic             mem_d_error_o,
   output logic [31:0]      mem_d_data_rd_o,
   output logic [TAG_W-1:0] mem_d_resp_tag_o,
   output logic             ext_rd_o,
   output logic [3:0]       ext_wr_o,
   output logic [31:0]      ext_addr_o,
   output logic [31:0]      ext_data_wr_o,
   input  logic             ext_accept_i,
   input  logic             ext_ack_i,
   input  logic             ext_error_i,
   input  logic [31:0]      ext_data_rd_i
);

   localparam logic             LP_RR      = (ROUND_ROBIN != 0);
   localparam logic             LP_WDOG_EN = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] LP_TO_LAST = (TIMEOUT_CYCLES > 0) ?
                                             CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   arb_state_e       r_state;
   owner_e           r_owner;
   owner_e           r_last;
   logic [TAG_W-1:0] r_tag;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ext_rd;
   logic [3:0]       r_ext_wr;
   logic [31:0]      r_ext_addr;
   logic [31:0]      r_ext_wdata;
   logic             r_i_valid;
   logic             r_i_err;
   logic [31:0]      r_i_inst;
   logic             r_d_ack;
   logic             r_d_err;
   logic [31:0]      r_d_rdata;
   logic [TAG_W-1:0] r_d_tag;

   logic             w_d_maint;
   logic             w_d_xfer;
   logic             w_d_req;
   logic             w_i_req;
   logic             w_idle;
   logic             w_grant;
   owner_e           w_win;
   logic             w_timeout;
   logic             w_rsp_fire;
   logic             w_rsp_err;
   logic [31:0]      w_rsp_data;
   logic             w_unused;

   assign w_d_maint = mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
   assign w_d_xfer  = mem_d_rd_i | (|mem_d_wr_i);
   assign w_d_req   = w_d_xfer | w_d_maint;
   assign w_i_req   = mem_i_rd_i;

   // Accepts are combinational so the winner's request is consumed in the grant cycle.
   assign w_idle         = (r_state == ST_IDLE) & ~rst_i;
   assign w_grant        = w_idle & (w_d_req | w_i_req);
   assign w_win          = pick_owner(w_d_req, w_i_req, LP_RR, r_last);
   assign mem_d_accept_o = w_grant & (w_win == OWNER_D);
   assign mem_i_accept_o = w_grant & (w_win == OWNER_I);

   // A real ack in the expiry cycle takes precedence over the watchdog.
   assign w_timeout  = LP_WDOG_EN & (r_cnt == LP_TO_LAST);
   assign w_rsp_fire = ext_ack_i | w_timeout;
   assign w_rsp_err  = ext_ack_i ? ext_error_i : 1'b1;
   assign w_rsp_data = ext_ack_i ? ext_data_rd_i : 32'h0;

   assign w_unused = ^{mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                       mem_i_pc_i[1:0], mem_d_addr_i[1:0]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_owner     <= OWNER_I;
         r_last      <= OWNER_I;
         r_tag       <= '0;
         r_cnt       <= '0;
         r_ext_rd    <= 1'b0;
         r_ext_wr    <= 4'h0;
         r_ext_addr  <= 32'h0;
         r_ext_wdata <= 32'h0;
         r_i_valid   <= 1'b0;
         r_i_err     <= 1'b0;
         r_i_inst    <= 32'h0;
         r_d_ack     <= 1'b0;
         r_d_err     <= 1'b0;
         r_d_rdata   <= 32'h0;
         r_d_tag     <= '0;
      end else begin
         r_i_valid <= 1'b0;
         r_d_ack   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_owner <= w_win;
                  r_last  <= w_win;
                  if (w_win == OWNER_D) begin
                     r_tag       <= mem_d_req_tag_i;
                     r_ext_addr  <= {mem_d_addr_i[31:2], 2'b00};
                     r_ext_wdata <= mem_d_data_wr_i;
                     if (w_d_xfer) begin
                        r_ext_rd <= mem_d_rd_i;
                        r_ext_wr <= mem_d_wr_i;
                        r_state  <= ST_REQ;
                     end else begin
                        r_state  <= ST_LOCAL;
                     end
                  end else begin
                     r_tag       <= '0;
                     r_ext_addr  <= {mem_i_pc_i[31:2], 2'b00};
                     r_ext_wdata <= 32'h0;
                     r_ext_rd    <= 1'b1;
                     r_ext_wr    <= 4'h0;
                     r_state     <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (ext_accept_i) begin
                  r_ext_rd <= 1'b0;
                  r_ext_wr <= 4'h0;
                  r_cnt    <= '0;
                  r_state  <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (w_rsp_fire) begin
                  if (r_owner == OWNER_D) begin
                     r_d_ack   <= 1'b1;
                     r_d_err   <= w_rsp_err;
                     r_d_rdata <= w_rsp_data;
                     r_d_tag   <= r_tag;
                  end else begin
                     r_i_valid <= 1'b1;
                     r_i_err   <= w_rsp_err;
                     r_i_inst  <= w_rsp_data;
                  end
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_LOCAL: begin
               r_d_ack <= 1'b1;
               r_d_err <= 1'b0;
               r_d_tag <= r_tag;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ext_rd_o         = r_ext_rd;
   assign ext_wr_o         = r_ext_wr;
   assign ext_addr_o       = r_ext_addr;
   assign ext_data_wr_o    = r_ext_wdata;
   assign mem_i_valid_o    = r_i_valid;
   assign mem_i_error_o    = r_i_err;
   assign mem_i_inst_o     = r_i_inst;
   assign mem_d_ack_o      = r_d_ack;
   assign mem_d_error_o    = r_d_err;
   assign mem_d_data_rd_o  = r_d_rdata;
   assign mem_d_resp_tag_o = r_d_tag;

endmodule

// File: tb/tb_mem_port_arb.sv
// Randomized bench for mem_port_arb: a transaction-level model predicts grant
// order, ext request timing and each response, plus a fixed-priority instance.
module tb_mem_port_arb;

   localparam bit RR = 1'b1;
   localparam int TO = 8;

   typedef struct {
      bit          is_d;
      bit          rd;
      logic [3:0]  wr;
      logic [2:0]  mop;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [10:0] tag;
      logic [31:0] rdata;
      bit          err;
      bit          noack;
      int          acc_dly;
      int          ack_dly;
   } txn_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        mem_i_rd_i = 1'b0;
   logic [31:0] mem_i_pc_i = 32'h0;
   logic        mem_i_flush_i = 1'b0;
   logic        mem_i_invalidate_i = 1'b0;
   logic [31:0] mem_d_addr_i = 32'h0;
   logic [31:0] mem_d_data_wr_i = 32'h0;
   logic        mem_d_rd_i = 1'b0;
   logic [3:0]  mem_d_wr_i = 4'h0;
   logic        mem_d_cacheable_i = 1'b0;
   logic [10:0] mem_d_req_tag_i = 11'h0;
   logic        mem_d_invalidate_i = 1'b0;
   logic        mem_d_writeback_i = 1'b0;
   logic        mem_d_flush_i = 1'b0;
   logic        ext_accept_i = 1'b0;
   logic        ext_ack_i = 1'b0;
   logic        ext_error_i = 1'b0;
   logic [31:0] ext_data_rd_i = 32'h0;

   logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
   logic [31:0] mem_i_inst_o;
   logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
   logic [31:0] mem_d_data_rd_o;
   logic [10:0] mem_d_resp_tag_o;
   logic        ext_rd_o;
   logic [3:0]  ext_wr_o;
   logic [31:0] ext_addr_o, ext_data_wr_o;

   logic        fp_i_rd = 1'b0;
   logic        fp_d_rd = 1'b0;
   logic        fp_i_acc, fp_i_vld, fp_i_err, fp_d_acc, fp_d_ack, fp_d_err, fp_ext_rd;
   logic [31:0] fp_i_inst, fp_d_data, fp_ext_addr, fp_ext_wdata;
   logic [10:0] fp_d_tag;
   logic [3:0]  fp_ext_wr;

   int n_tests = 0;
   int n_fail  = 0;
   bit last_i  = 1'b1;

   always #5 clk_i = ~clk_i;

   mem_port_arb #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(TO)) u_dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mem_i_rd_i(mem_i_rd_i), .mem_i_pc_i(mem_i_pc_i),
      .mem_i_flush_i(mem_i_flush_i), .mem_i_invalidate_i(mem_i_invalidate_i),
      .mem_i_accept_o(mem_i_accept_o), .mem_i_valid_o(mem_i_valid_o),
      .mem_i_error_o(mem_i_error_o), .mem_i_inst_o(mem_i_inst_o),
      .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
      .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i),
      .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_req_tag_i(mem_d_req_tag_i),
      .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
      .mem_d_flush_i(mem_d_flush_i),
      .mem_d_accept_o(mem_d_accept_o), .mem_d_ack_o(mem_d_ack_o),
      .mem_d_error_o(mem_d_error_o), .mem_d_data_rd_o(mem_d_data_rd_o),
      .mem_d_resp_tag_o(mem_d_resp_tag_o),
      .ext_rd_o(ext_rd_o), .ext_wr_o(ext_wr_o), .ext_addr_o(ext_addr_o),
      .ext_data_wr_o(ext_data_wr_o), .ext_accept_i(ext_accept_i),
      .ext_ack_i(ext_ack_i), .ext_error_i(ext_error_i), .ext_data_rd_i(ext_data_rd_i)
   );

   mem_port_arb #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(0)) u_fp (
      .clk_i(clk_i), .rst_i(rst_i),
      .mem_i_rd_i(fp_i_rd), .mem_i_pc_i(32'h0000_1000),
      .mem_i_flush_i(1'b0), .mem_i_invalidate_i(1'b0),
      .mem_i_accept_o(fp_i_acc), .mem_i_valid_o(fp_i_vld),
      .mem_i_error_o(fp_i_err), .mem_i_inst_o(fp_i_inst),
      .mem_d_addr_i(32'h0000_2000), .mem_d_data_wr_i(32'h0),
      .mem_d_rd_i(fp_d_rd), .mem_d_wr_i(4'h0),
      .mem_d_cacheable_i(1'b0), .mem_d_req_tag_i(11'h155),
      .mem_d_invalidate_i(1'b0), .mem_d_writeback_i(1'b0), .mem_d_flush_i(1'b0),
      .mem_d_accept_o(fp_d_acc), .mem_d_ack_o(fp_d_ack),
      .mem_d_error_o(fp_d_err), .mem_d_data_rd_o(fp_d_data),
      .mem_d_resp_tag_o(fp_d_tag),
      .ext_rd_o(fp_ext_rd), .ext_wr_o(fp_ext_wr), .ext_addr_o(fp_ext_addr),
      .ext_data_wr_o(fp_ext_wdata), .ext_accept_i(1'b1),
      .ext_ack_i(1'b1), .ext_error_i(1'b0), .ext_data_rd_i(32'h0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic smp();
      @(negedge clk_i);
   endtask

   function automatic txn_t rnd_txn(input bit is_d);
      txn_t t;
      t.is_d    = is_d;
      t.addr    = $urandom;
      t.wdata   = $urandom;
      t.tag     = 11'($urandom);
      t.rdata   = $urandom;
      t.err     = ($urandom_range(0, 7) == 0);
      t.noack   = 1'b0;
      t.acc_dly = $urandom_range(0, 3);
      t.ack_dly = $urandom_range(0, 3);
      t.rd      = !is_d;
      t.wr      = 4'h0;
      t.mop     = 3'h0;
      if (is_d) begin
         case ($urandom_range(0, 3))
            0, 1:    t.rd  = 1'b1;
            2:       t.wr  = 4'($urandom_range(1, 15));
            default: t.mop = 3'(1 << $urandom_range(0, 2));
         endcase
      end
      return t;
   endfunction

   task automatic drive_req(input txn_t t);
      if (t.is_d) begin
         mem_d_rd_i      = t.rd;
         mem_d_wr_i      = t.wr;
         mem_d_addr_i    = t.addr;
         mem_d_data_wr_i = t.wdata;
         mem_d_req_tag_i = t.tag;
         {mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i} = t.mop;
      end else begin
         mem_i_rd_i = 1'b1;
         mem_i_pc_i = t.addr;
      end
   endtask

   task automatic drop_req(input bit is_d);
      if (is_d) begin
         mem_d_rd_i = 1'b0;
         mem_d_wr_i = 4'h0;
         {mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i} = 3'b000;
      end else begin
         mem_i_rd_i = 1'b0;
      end
   endtask

   task automatic chk_quiet();
      chk("i_pulse_idle", mem_i_valid_o, 0);
      chk("d_pulse_idle", mem_d_ack_o, 0);
   endtask

   // Entered after the grant-cycle sample; leaves after sampling the response cycle.
   task automatic serve(input txn_t t, input bit has_l, input bit l_is_d);
      logic        exp_err;
      logic [31:0] exp_data;
      cyc();
      drop_req(t.is_d);
      ext_accept_i = 1'b0;
      ext_ack_i    = 1'b0;
      if (t.is_d && !t.rd && t.wr == 4'h0) begin
         smp();
         chk("loc_ext_rd", ext_rd_o, 0);
         chk("loc_ext_wr", ext_wr_o, 0);
         chk("loc_early", mem_d_ack_o, 0);
         if (has_l) chk("loc_hold", l_is_d ? mem_d_accept_o : mem_i_accept_o, 0);
         cyc();
         smp();
         chk("loc_ext_rd2", ext_rd_o, 0);
         chk("loc_ack", mem_d_ack_o, 1);
         chk("loc_err", mem_d_error_o, 0);
         chk("loc_tag", mem_d_resp_tag_o, t.tag);
      end else begin
         for (int k = 0; k <= t.acc_dly; k++) begin
            if (k > 0) cyc();
            ext_accept_i = (k == t.acc_dly);
            smp();
            chk("ext_rd", ext_rd_o, t.rd);
            chk("ext_wr", ext_wr_o, t.wr);
            chk("ext_addr", ext_addr_o, t.addr & 32'hFFFF_FFFC);
            if (t.wr != 4'h0) chk("ext_wdata", ext_data_wr_o, t.wdata);
            chk_quiet();
            if (has_l) chk("req_hold", l_is_d ? mem_d_accept_o : mem_i_accept_o, 0);
         end
         cyc();
         ext_accept_i = 1'b0;
         if (t.noack) begin
            for (int k = 0; k < TO; k++) begin
               smp();
               chk("wd_ext_rd", ext_rd_o, 0);
               chk_quiet();
               cyc();
            end
         end else begin
            for (int k = 0; k <= t.ack_dly; k++) begin
               if (k > 0) cyc();
               ext_ack_i     = (k == t.ack_dly);
               ext_error_i   = ext_ack_i ? t.err : 1'b0;
               ext_data_rd_i = t.rdata;
               smp();
               chk("resp_ext_rd", ext_rd_o, 0);
               chk("resp_ext_wr", ext_wr_o, 0);
               chk_quiet();
               if (has_l) chk("resp_hold", l_is_d ? mem_d_accept_o : mem_i_accept_o, 0);
            end
            cyc();
         end
         ext_ack_i   = 1'b0;
         ext_error_i = 1'b0;
         smp();
         exp_err  = t.noack ? 1'b1 : t.err;
         exp_data = t.noack ? 32'h0 : t.rdata;
         if (t.is_d) begin
            chk("d_ack", mem_d_ack_o, 1);
            chk("d_err", mem_d_error_o, exp_err);
            chk("d_tag", mem_d_resp_tag_o, t.tag);
            chk("d_i_quiet", mem_i_valid_o, 0);
            if (t.rd || t.noack) chk("d_data", mem_d_data_rd_o, exp_data);
         end else begin
            chk("i_valid", mem_i_valid_o, 1);
            chk("i_inst", mem_i_inst_o, exp_data);
            chk("i_err", mem_i_error_o, exp_err);
            chk("i_d_quiet", mem_d_ack_o, 0);
         end
      end
      if (has_l) chk("loser_acc", l_is_d ? mem_d_accept_o : mem_i_accept_o, 1);
   endtask

   task automatic start(input bit has_i, input txn_t ti, input bit has_d, input txn_t td);
      bit win_d;
      cyc();
      if (has_i) drive_req(ti);
      if (has_d) drive_req(td);
      smp();
      chk_quiet();
      win_d = has_d && (!has_i || !RR || last_i);
      chk("acc_i", mem_i_accept_o, has_i && !win_d);
      chk("acc_d", mem_d_accept_o, win_d);
      last_i = !win_d;
      if (win_d) begin
         serve(td, has_i, 1'b0);
         if (has_i) begin last_i = 1'b1; serve(ti, 1'b0, 1'b0); end
      end else begin
         serve(ti, has_d, 1'b1);
         if (has_d) begin last_i = 1'b0; serve(td, 1'b0, 1'b0); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      txn_t a, b;
      int   d_acc, i_acc, d_ok;

      #12;
      mem_i_rd_i = 1'b1;
      mem_d_rd_i = 1'b1;
      #1;
      chk("rst_acc_i", mem_i_accept_o, 0);
      chk("rst_acc_d", mem_d_accept_o, 0);
      chk("rst_ext_rd", ext_rd_o, 0);
      chk("rst_ext_addr", ext_addr_o, 0);
      chk("rst_i_valid", mem_i_valid_o, 0);
      chk("rst_d_ack", mem_d_ack_o, 0);
      chk("rst_d_tag", mem_d_resp_tag_o, 0);
      mem_i_rd_i = 1'b0;
      mem_d_rd_i = 1'b0;
      @(posedge clk_i);
      #1 rst_i = 1'b0;

      a = rnd_txn(1'b0);
      a.addr = 32'h8000_0010; a.rdata = 32'h0000_0013;
      a.acc_dly = 0; a.ack_dly = 0; a.err = 1'b0;
      start(1'b1, a, 1'b0, a);

      a = rnd_txn(1'b0); a.err = 1'b0;
      b = rnd_txn(1'b1);
      b.rd = 1'b1; b.wr = 4'h0; b.mop = 3'h0; b.tag = 11'h155; b.err = 1'b0;
      start(1'b1, a, 1'b1, b);
      start(1'b1, a, 1'b1, b);

      b = rnd_txn(1'b1);
      b.rd = 1'b0; b.wr = 4'b0100; b.mop = 3'h0; b.addr = 32'h8000_0102;
      b.wdata = 32'hAABB_CCDD; b.acc_dly = 5; b.err = 1'b0;
      start(1'b0, a, 1'b1, b);

      b = rnd_txn(1'b1);
      b.rd = 1'b0; b.wr = 4'h0; b.mop = 3'b001; b.tag = 11'h7FF;
      start(1'b0, a, 1'b1, b);

      b = rnd_txn(1'b1);
      b.rd = 1'b1; b.wr = 4'h0; b.mop = 3'h0; b.err = 1'b1;
      start(1'b0, a, 1'b1, b);

      b = rnd_txn(1'b1);
      b.rd = 1'b1; b.wr = 4'h0; b.mop = 3'h0; b.noack = 1'b1;
      start(1'b0, a, 1'b1, b);
      cyc();
      ext_ack_i = 1'b1;
      ext_data_rd_i = 32'hDEAD_BEEF;
      smp();
      chk_quiet();
      cyc();
      ext_ack_i = 1'b0;
      smp();
      chk("late_ack_i", mem_i_valid_o, 0);
      chk("late_ack_d", mem_d_ack_o, 0);
      a = rnd_txn(1'b0);
      start(1'b1, a, 1'b0, a);

      a = rnd_txn(1'b0);
      cyc();
      drive_req(a);
      smp();
      chk("rr_acc", mem_i_accept_o, 1);
      cyc();
      drop_req(1'b0);
      ext_accept_i = 1'b1;
      smp();
      chk("rr_ext_rd", ext_rd_o, 1);
      cyc();
      ext_accept_i = 1'b0;
      mem_i_rd_i = 1'b1;
      #2 rst_i = 1'b1;
      #1;
      chk("mid_rst_acc", mem_i_accept_o, 0);
      chk("mid_rst_addr", ext_addr_o, 0);
      chk("mid_rst_rd", ext_rd_o, 0);
      chk("mid_rst_inst", mem_i_inst_o, 0);
      chk("mid_rst_tag", mem_d_resp_tag_o, 0);
      chk("mid_rst_valid", mem_i_valid_o, 0);
      mem_i_rd_i = 1'b0;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      last_i = 1'b1;
      a = rnd_txn(1'b0);
      a.noack = 1'b0;
      start(1'b1, a, 1'b0, a);

      for (int n = 0; n < 40; n++) begin
         int sel;
         sel = $urandom_range(0, 2);
         a = rnd_txn(1'b0);
         b = rnd_txn(1'b1);
         a.noack = ($urandom_range(0, 11) == 0);
         b.noack = ($urandom_range(0, 11) == 0);
         start(sel != 1, a, sel != 0, b);
      end

      cyc();
      fp_i_rd = 1'b1;
      fp_d_rd = 1'b1;
      d_acc = 0;
      i_acc = 0;
      d_ok  = 0;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) cyc();
         smp();
         d_acc += int'(fp_d_acc);
         i_acc += int'(fp_i_acc);
         if (fp_d_ack && fp_d_tag == 11'h155) d_ok++;
      end
      fp_i_rd = 1'b0;
      fp_d_rd = 1'b0;
      chk("fp_d_grants", d_acc, 4);
      chk("fp_i_grants", i_acc, 0);
      chk("fp_d_acks", d_ok, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
